// File: rtl/epsilon_bandit.sv
// Epsilon-greedy multi-armed bandit: table of action values, sequential argmax scan,
// LFSR-driven exploration and an exponential-recency value update per observed reward.
module epsilon_bandit #(
  parameter int unsigned ARMS = 256,
  parameter int unsigned REWARD_WIDTH = 8,
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned ALPHA_SHIFT = 3,
  parameter int unsigned EPSILON = 0,
  parameter logic signed [VALUE_WIDTH-1:0] INIT_VALUE = '0,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int unsigned IDX_W = (ARMS > 1) ? $clog2(ARMS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reward_valid,
  input  logic [REWARD_WIDTH-1:0] reward_data,
  output logic                    reward_ready,
  output logic                    action_valid,
  output logic [IDX_W-1:0]        action_data,
  output logic                    action_explore,
  input  logic                    action_ready
);

  localparam int unsigned DW = VALUE_WIDTH + 1;
  localparam logic [8:0] EPS9 = 9'(EPSILON);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARMS - 1);

  typedef enum logic [2:0] {
    StInit,
    StDecide,
    StAct,
    StObserve,
    StUpdate
  } state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic signed [VALUE_WIDTH-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0] data_q, data_d;
  logic explore_q, explore_d;
  logic signed [REWARD_WIDTH-1:0] reward_q, reward_d;
  logic [15:0] lfsr_q, lfsr_next;

  logic signed [VALUE_WIDTH-1:0] q_mem [ARMS];

  logic [IDX_W-1:0] rd_idx;
  logic signed [VALUE_WIDTH-1:0] rd_val;
  logic take_entry;
  logic [IDX_W-1:0] cand_idx;
  logic signed [VALUE_WIDTH-1:0] cand_val;
  logic do_explore;
  logic signed [DW-1:0] r_ext, q_ext, diff, step;
  logic signed [VALUE_WIDTH-1:0] new_val;

  assign reward_ready   = (state_q == StObserve);
  assign action_valid   = (state_q == StAct);
  assign action_data    = data_q;
  assign action_explore = explore_q;

  // Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  // The table is only read by the scan and by the update of the chosen arm.
  assign rd_idx = (state_q == StUpdate) ? data_q : idx_q;
  assign rd_val = q_mem[rd_idx];

  // Entry 0 always seeds the scan so stale bests from earlier rounds never leak in.
  assign take_entry = (idx_q == '0) || (rd_val > best_val_q);
  assign cand_idx   = take_entry ? idx_q : best_idx_q;
  assign cand_val   = take_entry ? rd_val : best_val_q;
  assign do_explore = ({1'b0, lfsr_q[7:0]} < EPS9);

  assign r_ext   = {{(DW - REWARD_WIDTH){reward_q[REWARD_WIDTH-1]}}, reward_q};
  assign q_ext   = {rd_val[VALUE_WIDTH-1], rd_val};
  assign diff    = r_ext - q_ext;
  assign step    = diff >>> ALPHA_SHIFT;
  assign new_val = VALUE_WIDTH'(q_ext + step);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    data_d     = data_q;
    explore_d  = explore_q;
    reward_d   = reward_q;
    unique case (state_q)
      StInit: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = StDecide;
      end
      StDecide: begin
        best_idx_d = cand_idx;
        best_val_d = cand_val;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d   = StAct;
          explore_d = do_explore;
          data_d    = do_explore ? lfsr_q[8 +: IDX_W] : cand_idx;
        end
      end
      StAct: begin
        if (action_ready) state_d = StObserve;
      end
      StObserve: begin
        if (reward_valid) begin
          state_d  = StUpdate;
          reward_d = reward_data;
        end
      end
      StUpdate: begin
        state_d = StDecide;
        idx_d   = '0;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StInit;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      data_q     <= '0;
      explore_q  <= 1'b0;
      reward_q   <= '0;
      lfsr_q     <= SEED;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      data_q     <= data_d;
      explore_q  <= explore_d;
      reward_q   <= reward_d;
      lfsr_q     <= lfsr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == StInit) begin
      q_mem[idx_q] <= INIT_VALUE;
    end else if (state_q == StUpdate) begin
      q_mem[data_q] <= new_val;
    end
  end

endmodule

// File: doc/epsilon_bandit.md
EPSILON_BANDIT -- requirements
Module: epsilon_bandit

Interface
REQ-001 Parameter ARMS, 256, number of arms; SHALL be a power of two, 2..256.
REQ-002 Parameter REWARD_WIDTH, 8, signed reward width, 2..VALUE_WIDTH-1.
REQ-003 Parameter VALUE_WIDTH, 16, signed action-value width.
REQ-004 Parameter ALPHA_SHIFT, 3, step size alpha = 2^-ALPHA_SHIFT, 0..VALUE_WIDTH-1.
REQ-005 Parameter EPSILON, 0, exploration threshold, 0..256; explore probability = EPSILON/256.
REQ-006 Parameter INIT_VALUE, 0, signed initial Q for every arm (optimistic start permitted).
REQ-007 Parameter SEED, 16'hACE1, LFSR seed; SHALL be nonzero.
REQ-008 clock  input  1  rising-edge clock for all state.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 reward_valid  input  1  reward handshake valid.
REQ-011 reward_data  input  REWARD_WIDTH  signed reward for the last issued action.
REQ-012 reward_ready  output  1  high only in OBSERVE.
REQ-013 action_valid  output  1  high only in ACT.
REQ-014 action_data  output  max(1,log2 ARMS)  chosen arm index.
REQ-015 action_explore  output  1  1 = action_data came from exploration, 0 = greedy.
REQ-016 action_ready  input  1  action handshake ready.

Function
REQ-017 States SHALL be INIT, DECIDE, ACT, OBSERVE, UPDATE; no other encodings are reachable.
REQ-018 INIT: write INIT_VALUE to entry i on cycle i, i = 0..ARMS-1; go to DECIDE after entry ARMS-1.
REQ-019 DECIDE: scan entries 0..ARMS-1, one per cycle, exactly ARMS cycles; best value/index SHALL be cleared at scan start so earlier rounds do not influence the result.
REQ-020 Argmax SHALL use a signed strict greater-than; ties SHALL resolve to the lowest index.
REQ-021 At DECIDE->ACT: if {1'b0,lfsr[7:0]} < EPSILON, action_data = lfsr[15:8] modulo ARMS and action_explore = 1; otherwise action_data = argmax and action_explore = 0.
REQ-022 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1; loads SEED on reset; advances every non-reset cycle.
REQ-023 ACT: action_valid = 1; action_data and action_explore SHALL stay stable until action_valid & action_ready; then go to OBSERVE.
REQ-024 OBSERVE: reward_ready = 1; on reward_valid & reward_ready, capture reward_data and go to UPDATE; reward_valid outside OBSERVE SHALL be ignored.
REQ-025 UPDATE (one cycle): Q[a] <= Q[a] + ((sext(R) - Q[a]) >>> ALPHA_SHIFT), with a = action_data and Q[a] read from the table (not the scan best); then go to DECIDE.
REQ-026 The difference SHALL be computed at VALUE_WIDTH+1 bits with an arithmetic (floor) shift; the result truncated to VALUE_WIDTH cannot overflow when |INIT_VALUE| and R fit VALUE_WIDTH-1 bits.
REQ-027 Round latency from entering DECIDE to action_valid SHALL be exactly ARMS cycles; UPDATE to next action_valid SHALL be ARMS+1 cycles.
REQ-028 EPSILON = 0 SHALL never explore; EPSILON = 256 SHALL always explore.

Reset
REQ-029 reset SHALL force INIT, entry counter 0, LFSR = SEED, action_valid = 0, reward_ready = 0, action_data = 0, action_explore = 0.
REQ-030 reset asserted in any state, including mid-handshake, SHALL abandon the round; any pending reward is discarded and the table is fully reinitialised.
REQ-031 Table contents SHALL be undefined until INIT completes; no output may depend on them before then.

Verification (ARMS=4, EPSILON=0, INIT_VALUE=0, ALPHA_SHIFT=3 unless stated)
REQ-032 Release reset, hold action_ready=1 -> action_valid rises exactly 8 cycles later (4 INIT + 4 DECIDE); action_data=0, action_explore=0.
REQ-033 Reward 80 on arm 0 -> Q0=10; next action_data=0; then reward -80 -> Q0=10+(-90>>>3)=-2; next action_data=1 (lowest-index tie at 0).
REQ-034 Hold action_ready=0 for 10 cycles in ACT -> action_valid stays 1, action_data/explore unchanged, reward_ready stays 0.
REQ-035 Pulse reward_valid in DECIDE and ACT -> no table change; assert reset during OBSERVE -> INIT reruns and all Q return to 0.
REQ-036 EPSILON=256, SEED=16'hACE1 -> every action has action_explore=1 and action_data = lfsr[15:8] mod 4, matching a reference-model LFSR.
REQ-037 INIT_VALUE=100, ARMS=4 -> first four rounds (reward 0 each) visit arms 0,1,2,3 in order.
